// File: rtl/fmap_stream_packer.sv
// fmap_stream_packer: packs a serial FP16 pixel stream into a flat channel-major frame and holds it until acknowledged
module fmap_stream_packer #(
  parameter int DATA_WIDTH    = 16,
  parameter int H             = 32,
  parameter int W             = 32,
  parameter int input_channel = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [DATA_WIDTH-1:0]                    in_data,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_last,
  output logic [input_channel*H*W*DATA_WIDTH-1:0]  image,
  output logic                                     frame_valid,
  input  logic                                     frame_ack,
  output logic                                     frame_err,
  output logic [15:0]                              pix_count
);
  localparam int NPIX = input_channel * H * W;
  localparam int IW = NPIX * DATA_WIDTH;
  localparam logic [15:0] W_LAST = 16'(W - 1);
  localparam logic [15:0] H_LAST = 16'(H - 1);
  localparam logic [15:0] P_LAST = 16'(NPIX - 1);
  typedef enum logic {FILL, FULL} state_t;
  state_t state_q, state_d;
  logic [15:0] col_q, col_d, row_q, row_d, ch_q, ch_d, pix_q, pix_d;
  logic [IW-1:0] image_q, image_d;
  logic err_q, err_d;
  logic acc, last_pix, col_wrap, row_wrap;
  logic [31:0] idx;
  assign in_ready = reset & (state_q == FILL);
  assign acc = in_valid & in_ready;
  assign last_pix = pix_q == P_LAST;
  assign col_wrap = col_q == W_LAST;
  assign row_wrap = row_q == H_LAST;
  assign idx = (32'(ch_q) * 32'(H) + 32'(row_q)) * 32'(W) + 32'(col_q);
  assign image = image_q;
  assign frame_valid = state_q == FULL;
  assign frame_err = err_q;
  assign pix_count = pix_q;
  // next state: write accepted pixel, advance or clear the raster counters, release frame on ack
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    ch_d = ch_q;
    pix_d = pix_q;
    image_d = image_q;
    err_d = 1'b0;
    if (acc) begin
      image_d[idx*DATA_WIDTH +: DATA_WIDTH] = in_data;
      if (last_pix || in_last) begin
        col_d = 16'd0;
        row_d = 16'd0;
        ch_d = 16'd0;
        pix_d = 16'd0;
        err_d = ~(last_pix & in_last);
        state_d = last_pix ? FULL : FILL;
      end else begin
        pix_d = pix_q + 16'd1;
        col_d = col_wrap ? 16'd0 : col_q + 16'd1;
        row_d = col_wrap ? (row_wrap ? 16'd0 : row_q + 16'd1) : row_q;
        ch_d = (col_wrap && row_wrap) ? ch_q + 16'd1 : ch_q;
      end
    end else if (state_q == FULL && frame_ack) begin
      state_d = FILL;
    end
  end
  // state register with synchronous active-low reset that also discards the partial frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FILL;
      col_q <= 16'd0;
      row_q <= 16'd0;
      ch_q <= 16'd0;
      pix_q <= 16'd0;
      image_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      ch_q <= ch_d;
      pix_q <= pix_d;
      image_q <= image_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_fmap_stream_packer.sv
// tb_fmap_stream_packer: random and directed stimulus against a pixel-array reference model
module tb_fmap_stream_packer;
  localparam int DW = 16, H = 3, W = 3, C = 2;
  localparam int NPIX = C * H * W;
  localparam int IW = NPIX * DW;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, frame_ack = 1'b0;
  logic in_ready, frame_valid, frame_err;
  logic [IW-1:0] image;
  logic [15:0] pix_count;
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] m_img [NPIX];
  int m_cnt = 0;
  bit m_full = 0, m_err = 0;
  always #5 clk = ~clk;
  fmap_stream_packer #(.DATA_WIDTH(DW), .H(H), .W(W), .input_channel(C)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .image(image), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .frame_err(frame_err), .pix_count(pix_count)
  );
  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [IW-1:0] model_image();
    logic [IW-1:0] r = '0;
    for (int k = 0; k < NPIX; k++) r[k*DW +: DW] = m_img[k];
    return r;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < NPIX; k++) m_img[k] = '0;
    m_cnt = 0;
    m_full = 0;
    m_err = 0;
  endtask
  task automatic cyc(input logic r, input logic v, input logic [DW-1:0] d, input logic l, input logic a);
    bit acc;
    reset = r;
    in_valid = v;
    in_data = d;
    in_last = l;
    frame_ack = a;
    #1;
    chk("in_ready", IW'(in_ready), IW'(r && !m_full));
    acc = r && !m_full && v;
    @(posedge clk);
    if (!r) model_reset();
    else begin
      m_err = 0;
      if (acc) begin
        m_img[m_cnt] = d;
        if (m_cnt == NPIX - 1) begin
          m_full = 1;
          m_err = !l;
          m_cnt = 0;
        end else if (l) begin
          m_err = 1;
          m_cnt = 0;
        end else m_cnt++;
      end else if (m_full && a) m_full = 0;
    end
    #1;
    chk("frame_valid", IW'(frame_valid), IW'(m_full));
    chk("frame_err", IW'(frame_err), IW'(m_err));
    chk("pix_count", IW'(pix_count), IW'(m_cnt));
    chk("image", image, model_image());
  endtask
  task automatic send_frame(input int n, input int last_at, input logic [DW-1:0] base, input int gap_pct);
    int k = 0, guard = 0;
    bit v;
    while (k < n && guard < 1000) begin
      v = ($urandom % 100) >= gap_pct;
      if (v && !m_full) begin
        cyc(1, 1, base + DW'(k), k == last_at, 0);
        k++;
      end else cyc(1, 0, DW'($urandom), 1'b0, 0);
      guard++;
    end
    if (k < n) chk("frame_budget", IW'(k), IW'(n));
  endtask
  initial begin
    model_reset();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 16'h1234, 0, 0);
    send_frame(NPIX, NPIX - 1, 16'h3C00, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, DW'($urandom), 1'($urandom), 0);
    cyc(1, 1, 16'hBEEF, 0, 1);
    cyc(1, 0, 0, 0, 0);
    send_frame(6, 5, 16'h4000, 0);
    cyc(1, 0, 0, 0, 1);
    send_frame(NPIX, NPIX - 1, DW'($urandom), 0);
    cyc(1, 0, 0, 0, 1);
    send_frame(NPIX, -1, 16'h5000, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    send_frame(NPIX, NPIX - 1, 16'h3C00, 50);
    cyc(1, 0, 0, 0, 1);
    send_frame(9, -1, 16'h3C00, 50);
    cyc(0, 1, 16'h7777, 0, 0);
    chk("reset_image", image, '0);
    chk("reset_pix", IW'(pix_count), '0);
    for (int i = 0; i < 200; i++)
      cyc(($urandom % 40) != 0, 1'($urandom), DW'($urandom), ($urandom % 12) == 0, 1'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
